mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4-input data multiplexer among four requesters. It takes one request per source and issues a one-hot grant. It drives the 2-bit mux select and presents the granted source's data on a single output. It sits in front of the shared 4:1 select path in the CPU datapath and replaces hard-wired select logic wherever several producers contend for one bus.

---
 rtl/mux4_rr_arbiter.sv | 89 ++++++++
 tb/tb_mux4_rr_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 data mux with one-hot grant.
// Define MUX_ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles when others wait.
module mux4_rr_arbiter #(
  parameter int size     = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      req_i,
  input  logic [size-1:0] data0_i,
  input  logic [size-1:0] data1_i,
  input  logic [size-1:0] data2_i,
  input  logic [size-1:0] data3_i,
  output logic [3:0]      grant_o,
  output logic [1:0]      select_o,
  output logic            valid_o,
  output logic [size-1:0] data_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [7:0] HOLD_TOP = 8'(MAX_HOLD - 1);
  state_t          r_state;
  logic [1:0]      r_last;
  logic [1:0]      r_sel;
  logic [3:0]      r_grant;
  logic            r_valid;
  logic [7:0]      r_hold;
  logic [1:0]      w_base;
  logic [3:0]      w_own;
  logic [3:0]      w_mask;
  logic [1:0]      w_pick;
  logic            w_found;
  logic            w_preempt;
  logic [size-1:0] w_data;
  assign w_base = (r_state == BUSY) ? r_sel : r_last;
  assign w_own  = (r_state == BUSY) ? (4'b0001 << r_sel) : 4'b0000;
  assign w_mask = req_i & ~w_own;
  // Scan from farthest to nearest so the nearest successor of w_base wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      if (w_mask[w_base + 2'(i)]) begin
        w_found = 1'b1;
        w_pick  = w_base + 2'(i);
      end
    end
  end
`ifdef MUX_ARB_TIMEOUT_EN
  assign w_preempt = (r_hold == HOLD_TOP) && w_found;
`else
  assign w_preempt = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_sel   <= 2'd0;
      r_grant <= 4'b0000;
      r_valid <= 1'b0;
      r_hold  <= 8'd0;
    end else if (r_state == IDLE) begin
      r_hold <= 8'd0;
      if (w_found) begin
        r_state <= BUSY;
        r_sel   <= w_pick;
        r_grant <= 4'b0001 << w_pick;
        r_valid <= 1'b1;
      end
    end else if (!req_i[r_sel] || w_preempt) begin
      r_last <= r_sel;
      r_hold <= 8'd0;
      if (w_found) begin
        r_sel   <= w_pick;
        r_grant <= 4'b0001 << w_pick;
      end else begin
        r_state <= IDLE;
        r_grant <= 4'b0000;
        r_valid <= 1'b0;
      end
    end else if (r_hold != HOLD_TOP) begin
      r_hold <= r_hold + 8'd1;
    end
  end
  assign w_data   = r_sel[1] ? (r_sel[0] ? data3_i : data2_i) : (r_sel[0] ? data1_i : data0_i);
  assign data_o   = r_valid ? w_data : '0;
  assign grant_o  = r_grant;
  assign select_o = r_sel;
  assign valid_o  = r_valid;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: scoreboard bench for mux4_rr_arbiter against a behavioural model.
module tb_mux4_rr_arbiter;
  localparam int MH = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  typedef struct packed {
    logic [3:0]  g;
    logic [1:0]  s;
    logic        v;
    logic [31:0] d;
  } exp_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [3:0]  req = 4'hf;
  logic [31:0] d [4];
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        valid;
  logic [31:0] dout;
  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          m_busy = 0;
  int          m_owner = 0;
  int          m_last = 3;
  int          m_hold = 0;
  int          m_sel = 0;
  always #5 clk = ~clk;
  mux4_rr_arbiter #(.size(32), .MAX_HOLD(MH)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req),
    .data0_i(d[0]), .data1_i(d[1]), .data2_i(d[2]), .data3_i(d[3]),
    .grant_o(grant), .select_o(sel), .valid_o(valid), .data_o(dout)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [3:0] r, input int base);
    for (int k = 1; k <= 4; k++)
      if (r[(base + k) % 4]) return (base + k) % 4;
    return -1;
  endfunction
  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 3; m_hold = 0; m_sel = 0;
  endtask
  task automatic model(input logic [3:0] r);
    int nxt;
    logic [3:0] others;
    if (!m_busy) begin
      nxt = pick(r, m_last);
      m_hold = 0;
      if (nxt >= 0) begin m_busy = 1; m_owner = nxt; m_sel = nxt; end
    end else begin
      others = r & ~(4'b0001 << m_owner);
      nxt = pick(others, m_owner);
      if (!r[m_owner] || (TO && m_hold == MH - 1 && nxt >= 0)) begin
        m_last = m_owner;
        m_hold = 0;
        if (nxt >= 0) begin m_owner = nxt; m_sel = nxt; end
        else m_busy = 0;
      end else if (m_hold < MH - 1) m_hold++;
    end
  endtask
  task automatic step(input string tag, input logic [3:0] r);
    exp_t e;
    req = r;
    model(r);
    e.g = m_busy ? 4'(1 << m_owner) : 4'b0000;
    e.s = 2'(m_sel);
    e.v = m_busy;
    e.d = m_busy ? d[m_owner] : 32'h0;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({tag, ".grant"}, 32'(grant), 32'(e.g));
    check({tag, ".sel"}, 32'(sel), 32'(e.s));
    check({tag, ".valid"}, 32'(valid), 32'(e.v));
    check({tag, ".data"}, dout, e.d);
  endtask
  initial begin
    d[0] = 32'h0000_A0A0; d[1] = 32'h1111_B1B1; d[2] = 32'hDEADBEEF; d[3] = 32'h3333_C3C3;
    repeat (2) @(posedge clk);
    #1;
    check("rst.grant", 32'(grant), 32'h0);
    check("rst.sel", 32'(sel), 32'h0);
    check("rst.valid", 32'(valid), 32'h0);
    check("rst.data", dout, 32'h0);
    @(negedge clk) rst_n = 1;
    step("first", 4'hf);
    check("first.const", 32'(grant), 32'h1);
    step("idle0", 4'h0);
    step("single", 4'b0100);
    check("single.const", dout, 32'hDEADBEEF);
    step("single.hold", 4'b0100);
    step("single.drop", 4'b0000);
    step("rot.start", 4'hf);
    for (int i = 0; i < 8; i++) step("rot", 4'hf & ~4'(1 << m_owner));
    step("rot.end", 4'h0);
    step("b2b.own", 4'b0010);
    step("b2b.pend", 4'b1010);
    step("b2b.hand", 4'b1000);
    check("b2b.const", 32'(grant), 32'h8);
    step("b2b.end", 4'h0);
    step("hold.own", 4'b0001);
    for (int i = 0; i < 24; i++) step("hold.contend", 4'b0101);
    step("hold.rel", 4'b0100);
    step("hold.end", 4'h0);
    step("solo.own", 4'b0001);
    for (int i = 0; i < 10; i++) step("solo", 4'b0001);
    step("solo.end", 4'h0);
    step("mrst.own", 4'b1000);
    step("mrst.hold", 4'b1000);
    #2 rst_n = 0;
    #1;
    check("mrst.grant", 32'(grant), 32'h0);
    check("mrst.valid", 32'(valid), 32'h0);
    check("mrst.data", dout, 32'h0);
    model_reset();
    @(negedge clk) rst_n = 1;
    step("mrst.after", 4'b1001);
    check("mrst.src0", 32'(grant), 32'h1);
    for (int i = 0; i < 200; i++) begin
      d[i % 4] = $urandom;
      step("rand", 4'($urandom_range(0, 15)));
      check("rand.onehot", 32'($countones(grant) <= 1), 32'h1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
